// File: rtl/image_frame_ctrl.sv
// Frame-accurate capture gate between an image source and the downstream path.
// Optional frame geometry checker enabled by defining FRAME_GEOM_CHECK_EN.
module image_frame_ctrl #(
    parameter logic [11:0] ROW_NUM = 12'd256,
    parameter logic [11:0] COL_NUM = 12'd256,
    parameter int          FCNT_W  = 16
) (
    input  logic              im_pclk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_mode,
    input  logic [FCNT_W-1:0] cmd_nframes,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_valid,
    input  logic [7:0]        in_dout,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_valid,
    output logic [7:0]        out_dout,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              geom_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state;
    logic              vsync_prev;
    logic              stop_pending;
    logic              mode_q;
    logic [FCNT_W-1:0] nframes_q;

    logic              frame_start;
    logic              frame_end;
    logic              start_ok;
    logic              forward;
    logic              last_frame;
    logic [FCNT_W-1:0] cnt_next;

    assign frame_start = vsync_prev & ~in_vsync;
    assign frame_end   = ~vsync_prev & in_vsync;
    assign start_ok    = cmd_start & ~(cmd_mode & (cmd_nframes == '0));
    assign cnt_next    = frame_cnt + FCNT_W'(1);
    assign last_frame  = stop_pending | cmd_stop | (mode_q & (cnt_next == nframes_q));

    // Forwarding begins on the frame-start cycle itself, so ARM passes that one cycle through
    assign forward = (state == CAPTURE) | ((state == ARM) & frame_start & ~cmd_stop);

    always_ff @(posedge im_pclk) begin
        if (rst) begin
            state        <= IDLE;
            vsync_prev   <= 1'b0;
            stop_pending <= 1'b0;
            mode_q       <= 1'b0;
            nframes_q    <= '0;
            out_vsync    <= 1'b1;
            out_hsync    <= 1'b1;
            out_valid    <= 1'b0;
            out_dout     <= 8'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            vsync_prev <= in_vsync;
            frame_done <= 1'b0;

            if (forward) begin
                out_vsync <= in_vsync;
                out_hsync <= in_hsync;
                out_valid <= in_valid;
                out_dout  <= in_dout;
            end else begin
                out_vsync <= 1'b1;
                out_hsync <= 1'b1;
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state        <= ARM;
                        busy         <= 1'b1;
                        mode_q       <= cmd_mode;
                        nframes_q    <= cmd_nframes;
                        frame_cnt    <= '0;
                        stop_pending <= 1'b0;
                    end
                end
                ARM: begin
                    if (cmd_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (frame_start) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cmd_stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (frame_end) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= cnt_next;
                        if (last_frame) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_GEOM_CHECK_EN
    logic        valid_prev;
    logic        line_err;
    logic [11:0] pix_cnt;
    logic [11:0] line_cnt;
    logic        valid_rise;
    logic        line_end_bad;

    assign valid_rise   = in_valid & ~valid_prev;
    assign line_end_bad = valid_prev & ~in_valid & (pix_cnt != COL_NUM);

    // Counts are pixels/lines seen so far; a line opening on the frame-start cycle still counts
    always_ff @(posedge im_pclk) begin
        if (rst) begin
            valid_prev <= 1'b0;
            line_err   <= 1'b0;
            pix_cnt    <= 12'd0;
            line_cnt   <= 12'd0;
            geom_err   <= 1'b0;
        end else begin
            valid_prev <= in_valid;
            geom_err   <= 1'b0;

            if (frame_start) begin
                pix_cnt  <= valid_rise ? 12'd1 : 12'd0;
                line_cnt <= valid_rise ? 12'd1 : 12'd0;
                line_err <= 1'b0;
            end else begin
                if (valid_rise) begin
                    pix_cnt <= 12'd1;
                    if (line_cnt != 12'hFFF) begin
                        line_cnt <= line_cnt + 12'd1;
                    end
                end else if (in_valid && pix_cnt != 12'hFFF) begin
                    pix_cnt <= pix_cnt + 12'd1;
                end
                if (line_end_bad) begin
                    line_err <= 1'b1;
                end
            end

            if (state == CAPTURE && frame_end) begin
                geom_err <= line_err | line_end_bad | (line_cnt != ROW_NUM);
            end
        end
    end
`else
    logic unused_geom_params;
    assign unused_geom_params = ^{ROW_NUM, COL_NUM};
    assign geom_err = 1'b0;
`endif

endmodule
